// File: rtl/weight_update_ctrl.sv
// -----------------------------------------------------------------------------
// weight_update_ctrl
//
// Sweeps M synapse weights held in an external registered-read RAM. For each
// address it adds a signed delta, saturates the result to [WMIN, WMAX] and
// writes it back. A two-stage pipeline (issue, then add/clamp) sustains one
// weight per cycle. The inference core may read the same RAM at any time;
// its requests take absolute priority and stall the update sweep.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       single-cycle pulse, begins a pass (honoured only in IDLE)
//   dw_in       signed delta for the address issued on the previous cycle
//   ram_data_r  RAM read data, valid one cycle after ram_addr_r
//   ext_req     inference-core read request (level, one read per cycle)
//   ext_addr    inference-core read address
//   ram_addr_r  RAM read address, also drives the delta source address
//   ram_addr_w  RAM write address
//   ram_data_w  RAM write data
//   ram_we      RAM write enable
//   ext_valid   ram_data_r holds the ext read issued last cycle
//   busy        high from the cycle after an accepted start through done
//   done        single-cycle pulse, pass complete
//   sat_cnt     number of clamped writes in the current/last pass
// -----------------------------------------------------------------------------
module weight_update_ctrl #(
    parameter int M    = 784,
    parameter int W    = 24,
    parameter int WMAX = 16*4096,
    parameter int WMIN = -16*4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] dw_in,
    input  logic signed [W-1:0] ram_data_r,
    input  logic                ext_req,
    input  logic [9:0]          ext_addr,
    output logic [9:0]          ram_addr_r,
    output logic [9:0]          ram_addr_w,
    output logic signed [W-1:0] ram_data_w,
    output logic                ram_we,
    output logic                ext_valid,
    output logic                busy,
    output logic                done,
    output logic [9:0]          sat_cnt
);

    localparam logic signed [W:0] C_WMAX    = (W+1)'(WMAX);
    localparam logic signed [W:0] C_WMIN    = (W+1)'(WMIN);
    localparam logic [9:0]        C_LAST    = 10'(M-1);
    localparam logic [9:0]        C_SAT_TOP = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [9:0]            r_index;
    logic                  r_s2_valid;
    logic [9:0]            r_s2_addr;
    logic [9:0]            r_ram_addr_w;
    logic signed [W-1:0]   r_ram_data_w;
    logic                  r_ram_we;
    logic                  r_ext_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [9:0]            r_sat_cnt;

    logic                  w_issue;
    logic signed [W:0]     w_sum;
    logic                  w_over;
    logic                  w_under;
    logic signed [W-1:0]   w_clamped;

    // The sweep only claims the read port in cycles the inference core leaves free.
    assign w_issue = (r_state == ST_RUN) && !ext_req;

    // Read address is combinational so the arbitration takes effect the same
    // cycle; reset forces it to zero without waiting for a clock.
    always_comb begin
        ram_addr_r = 10'd0;
        if (rst) begin
            ram_addr_r = 10'd0;
        end else if (ext_req) begin
            ram_addr_r = ext_addr;
        end else if (r_state == ST_RUN) begin
            ram_addr_r = r_index;
        end
    end

    // One extra bit so the raw sum never wraps before the clamp looks at it.
    assign w_sum     = {ram_data_r[W-1], ram_data_r} + {dw_in[W-1], dw_in};
    assign w_over    = (w_sum > C_WMAX);
    assign w_under   = (w_sum < C_WMIN);
    assign w_clamped = w_over  ? C_WMAX[W-1:0] :
                       w_under ? C_WMIN[W-1:0] :
                                 w_sum[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= 10'd0;
            r_s2_valid   <= 1'b0;
            r_s2_addr    <= 10'd0;
            r_ram_addr_w <= 10'd0;
            r_ram_data_w <= '0;
            r_ram_we     <= 1'b0;
            r_ext_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sat_cnt    <= 10'd0;
        end else begin
            r_ext_valid <= ext_req;
            r_done      <= 1'b0;

            // Stage 1 -> stage 2 tag.
            r_s2_valid <= w_issue;
            if (w_issue) begin
                r_s2_addr <= r_index;
            end

            // Stage 2: read data and delta are both present this cycle.
            r_ram_we <= r_s2_valid;
            if (r_s2_valid) begin
                r_ram_addr_w <= r_s2_addr;
                r_ram_data_w <= w_clamped;
                if ((w_over || w_under) && (r_sat_cnt != C_SAT_TOP)) begin
                    r_sat_cnt <= r_sat_cnt + 10'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_index   <= 10'd0;
                        r_sat_cnt <= 10'd0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        // Index parks at the last address instead of wrapping.
                        if (r_index == C_LAST) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_index <= r_index + 10'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last write is being registered or already out; nothing
                    // left to wait for once stage 2 is empty.
                    if (!r_s2_valid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr_w = r_ram_addr_w;
    assign ram_data_w = r_ram_data_w;
    assign ram_we     = r_ram_we;
    assign ext_valid  = r_ext_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_weight_update_ctrl.sv
module tb_weight_update_ctrl;

    localparam int M    = 4;
    localparam int W    = 24;
    localparam int WMAX = 16*4096;
    localparam int WMIN = -16*4096;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic signed [W-1:0] dw_in;
    logic signed [W-1:0] ram_data_r;
    logic                ext_req = 1'b0;
    logic [9:0]          ext_addr = 10'd0;
    logic [9:0]          ram_addr_r;
    logic [9:0]          ram_addr_w;
    logic signed [W-1:0] ram_data_w;
    logic                ram_we;
    logic                ext_valid;
    logic                busy;
    logic                done;
    logic [9:0]          sat_cnt;

    weight_update_ctrl #(
        .M(M), .W(W), .WMAX(WMAX), .WMIN(WMIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dw_in      (dw_in),
        .ram_data_r (ram_data_r),
        .ext_req    (ext_req),
        .ext_addr   (ext_addr),
        .ram_addr_r (ram_addr_r),
        .ram_addr_w (ram_addr_w),
        .ram_data_w (ram_data_w),
        .ram_we     (ram_we),
        .ext_valid  (ext_valid),
        .busy       (busy),
        .done       (done),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight RAM and delta source models: registered read, read-before-write.
    logic signed [W-1:0] mem    [0:1023];
    logic signed [W-1:0] dw_mem [0:1023];
    always @(posedge clk) begin
        ram_data_r <= mem[ram_addr_r];
        dw_in      <= dw_mem[ram_addr_r];
        if (ram_we === 1'b1) mem[ram_addr_w] = ram_data_w;
    end

    typedef struct {
        logic [9:0]          addr;
        logic signed [W-1:0] data;
    } wr_t;

    wr_t                 sb[$];
    logic signed [W-1:0] ext_q[$];
    int                  we_cyc[$];
    int                  ext_cyc[$];
    wr_t                 mon_w;
    logic signed [W-1:0] mon_x;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] upd(input longint w, input longint d);
        longint s;
        s = w + d;
        if (s > WMAX) s = WMAX;
        if (s < WMIN) s = WMIN;
        return W'(s);
    endfunction

    task automatic load(input int a, input longint w, input longint d, input bit push);
        wr_t e;
        mem[a]    = W'(w);
        dw_mem[a] = W'(d);
        if (push) begin
            e.addr = 10'(a);
            e.data = upd(w, d);
            sb.push_back(e);
        end
    endtask

    // Write / ext-read monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL wr_unexpected observed addr=%0d expected no write", ram_addr_w);
            end
            if (sb.size() > 0) begin
                mon_w = sb.pop_front();
                chk("wr_addr", 64'(ram_addr_w), 64'(mon_w.addr));
                chk("wr_data", 64'(ram_data_w), 64'(mon_w.data));
            end
            we_cyc.push_back(cyc);
        end
        if (ext_valid === 1'b1) begin
            total++;
            assert (ext_q.size() > 0) else begin
                bad++;
                $error("FAIL ext_unexpected observed ext_valid=1 expected 0");
            end
            if (ext_q.size() > 0) begin
                mon_x = ext_q.pop_front();
                chk("ext_data", 64'(ram_data_r), 64'(mon_x));
            end
            ext_cyc.push_back(cyc);
        end
    end

    task automatic pulse_start(output int a);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = cyc;
    endtask

    task automatic wait_done(input int lim, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        total++;
        assert (dcyc >= 0) else begin
            bad++;
            $error("FAIL done_timeout observed=none expected=done within %0d cycles", lim);
        end
    endtask

    // Checks write count and first/last write cycle of the pass since base.
    task automatic chk_writes(input string tag, input int base, input int n, input int first, input int last);
        int fw;
        int lw;
        fw = (we_cyc.size() > base) ? we_cyc[base] : -1;
        lw = (we_cyc.size() >= base + n && n > 0) ? we_cyc[base + n - 1] : -1;
        chk({tag, "_nwr"},   64'(we_cyc.size() - base), 64'(n));
        chk({tag, "_first"}, 64'(fw), 64'(first));
        chk({tag, "_last"},  64'(lw), 64'(last));
    endtask

    initial begin
        int a;
        int d;
        int base;
        int ebase;

        for (int i = 0; i < 1024; i++) begin
            mem[i]    = '0;
            dw_mem[i] = '0;
        end

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_we",     64'(ram_we),     64'(0));
        chk("rst_busy",   64'(busy),       64'(0));
        chk("rst_done",   64'(done),       64'(0));
        chk("rst_extv",   64'(ext_valid),  64'(0));
        chk("rst_sat",    64'(sat_cnt),    64'(0));
        chk("rst_addr_r", 64'(ram_addr_r), 64'(0));
        chk("rst_addr_w", 64'(ram_addr_w), 64'(0));
        chk("rst_data_w", 64'(ram_data_w), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // ---- basic pass: {10,20,30,40} + {1,-2,3,-4} ----
        load(0, 10, 1, 1);
        load(1, 20, -2, 1);
        load(2, 30, 3, 1);
        load(3, 40, -4, 1);
        base = we_cyc.size();
        pulse_start(a);
        chk("p1_busy_start", 64'(busy), 64'(1));
        wait_done(30, d);
        chk("p1_done_cyc", 64'(d), 64'(a + 6));
        chk("p1_busy_done", 64'(busy), 64'(1));
        chk("p1_sat", 64'(sat_cnt), 64'(0));
        chk_writes("p1", base, 4, a + 2, a + 5);
        chk("p1_sb_left", 64'(sb.size()), 64'(0));
        @(negedge clk);
        chk("p1_busy_after", 64'(busy), 64'(0));
        chk("p1_done_after", 64'(done), 64'(0));
        chk("p1_mem1", 64'(mem[1]), 64'(upd(20, -2)));

        // ---- saturation, including a sum that overflows W bits ----
        load(0, WMAX - 1, 5, 1);
        load(1, WMIN + 1, -5, 1);
        load(2, 8388607, 8388607, 1);
        load(3, 0, 0, 1);
        base = we_cyc.size();
        pulse_start(a);
        chk("p2_sat_cleared", 64'(sat_cnt), 64'(0));
        wait_done(30, d);
        chk("p2_done_cyc", 64'(d), 64'(a + 6));
        chk("p2_sat", 64'(sat_cnt), 64'(3));
        chk_writes("p2", base, 4, a + 2, a + 5);
        @(negedge clk);
        @(negedge clk);
        chk("p2_sat_hold", 64'(sat_cnt), 64'(3));

        // ---- idle ext read and address mux ----
        load(0, 5, 0, 0);
        load(1, 6, 1, 0);
        load(2, 7, 0, 0);
        load(3, 8, -1, 0);
        ebase = ext_cyc.size();
        ext_req  = 1'b1;
        ext_addr = 10'd3;
        ext_q.push_back(W'(8));
        #1;
        chk("idle_addr_ext", 64'(ram_addr_r), 64'(3));
        chk("idle_we", 64'(ram_we), 64'(0));
        @(negedge clk);
        ext_req = 1'b0;
        #1;
        chk("idle_addr_zero", 64'(ram_addr_r), 64'(0));
        @(negedge clk);
        chk("idle_ext_n", 64'(ext_cyc.size() - ebase), 64'(1));

        // ---- ext_req held 3 cycles mid-pass ----
        load(0, 5, 0, 1);
        load(1, 6, 1, 1);
        load(2, 7, 0, 1);
        load(3, 8, -1, 1);
        base  = we_cyc.size();
        ebase = ext_cyc.size();
        pulse_start(a);
        @(negedge clk);
        ext_req  = 1'b1;
        ext_addr = 10'd2;
        ext_q.push_back(W'(7));
        #1;
        chk("p3_addr_ext", 64'(ram_addr_r), 64'(2));
        @(negedge clk);
        ext_addr = 10'd3;
        ext_q.push_back(W'(8));
        @(negedge clk);
        ext_addr = 10'd0;
        ext_q.push_back(W'(5));
        @(negedge clk);
        ext_req = 1'b0;
        #1;
        chk("p3_addr_run", 64'(ram_addr_r), 64'(1));
        wait_done(30, d);
        chk("p3_done_cyc", 64'(d), 64'(a + 9));
        chk_writes("p3", base, 4, a + 2, a + 8);
        chk("p3_ext_n", 64'(ext_cyc.size() - ebase), 64'(3));
        chk("p3_ext_first", 64'((ext_cyc.size() > ebase) ? ext_cyc[ebase] : -1), 64'(a + 2));
        chk("p3_ext_left", 64'(ext_q.size()), 64'(0));

        // ---- start ignored in RUN and DONE ----
        @(negedge clk);
        load(0, WMAX, 1, 1);
        load(1, 1, 0, 1);
        load(2, 2, 0, 1);
        load(3, 3, 0, 1);
        base = we_cyc.size();
        pulse_start(a);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("p4_sat_run", 64'(sat_cnt), 64'(1));
        wait_done(30, d);
        chk("p4_done_cyc", 64'(d), 64'(a + 6));
        chk("p4_sat_done", 64'(sat_cnt), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("p4_busy_idle", 64'(busy), 64'(0));
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("p4_busy_late", 64'(busy), 64'(0));
        chk("p4_sat_late", 64'(sat_cnt), 64'(1));
        chk_writes("p4", base, 4, a + 2, a + 5);

        // ---- reset after address 1 issued ----
        load(0, 65000, 1000, 1);
        load(1, 10, 1, 0);
        load(2, 20, 1, 0);
        load(3, 30, 1, 0);
        base = we_cyc.size();
        pulse_start(a);
        @(negedge clk);
        @(negedge clk);
        chk("p5_sat_pre", 64'(sat_cnt), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("p5_we_async",   64'(ram_we),     64'(0));
        chk("p5_busy_async", 64'(busy),       64'(0));
        chk("p5_sat_async",  64'(sat_cnt),    64'(0));
        chk("p5_addr_w",     64'(ram_addr_w), 64'(0));
        chk("p5_data_w",     64'(ram_data_w), 64'(0));
        chk("p5_addr_r",     64'(ram_addr_r), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("p5_mem0", 64'(mem[0]), 64'(W'(65000)));
        chk("p5_mem1", 64'(mem[1]), 64'(W'(10)));
        chk("p5_nwr", 64'(we_cyc.size() - base), 64'(1));

        // ---- restart from address 0 ----
        load(0, 65000, 1000, 1);
        load(1, 10, 1, 1);
        load(2, 20, 1, 1);
        load(3, 30, 1, 1);
        base = we_cyc.size();
        pulse_start(a);
        wait_done(30, d);
        chk("p6_done_cyc", 64'(d), 64'(a + 6));
        chk("p6_sat", 64'(sat_cnt), 64'(1));
        chk_writes("p6", base, 4, a + 2, a + 5);
        @(negedge clk);
        chk("p6_sb_left", 64'(sb.size()), 64'(0));
        chk("p6_mem3", 64'(mem[3]), 64'(W'(31)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_update_ctrl.md
WEIGHT_UPDATE_CTRL -- requirements
Module: weight_update_ctrl

Interface
REQ-001 Parameter M, default 784, number of synapse weights swept per update pass.
REQ-002 Parameter W, default 24, weight and delta width, two's complement.
REQ-003 Parameter WMAX, default 16*4096, upper saturation bound, inclusive.
REQ-004 Parameter WMIN, default -16*4096, lower saturation bound, inclusive.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle pulse, begins an update pass.
REQ-008 dw_in  in  W  signed weight delta for address issued on the previous cycle (source has 1-cycle latency).
REQ-009 ram_data_r  in  W  weight RAM read data, registered, valid 1 cycle after ram_addr_r.
REQ-010 ext_req  in  1  inference-core read request, level, one read per asserted cycle.
REQ-011 ext_addr  in  10  inference-core read address.
REQ-012 ram_addr_r  out  10  weight RAM read address; also drives delta source address.
REQ-013 ram_addr_w  out  10  weight RAM write address.
REQ-014 ram_data_w  out  W  weight RAM write data.
REQ-015 ram_we  out  1  weight RAM write enable.
REQ-016 ext_valid  out  1  ram_data_r holds data for the ext read issued last cycle.
REQ-017 busy  out  1  high from cycle after accepted start until done pulse, inclusive.
REQ-018 done  out  1  single-cycle pulse, pass complete.
REQ-019 sat_cnt  out  10  count of clamped writes in current/last pass, saturates at 1023.

Function
REQ-020 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after address M-1 issued; DRAIN->DONE when no write in flight; DONE->IDLE unconditionally after one cycle.
REQ-021 start SHALL be ignored outside IDLE; accepted start SHALL clear sat_cnt and index to 0.
REQ-022 Arbitration: ext_req has absolute priority; when ext_req=1, ram_addr_r=ext_addr and no update read is issued that cycle.
REQ-023 ext_valid SHALL equal ext_req delayed one cycle, in every state.
REQ-024 In RUN with ext_req=0: ram_addr_r=index, index increments by 1; issue tag (valid, address) registered for stage 2.
REQ-025 Stage 2 (cycle after issue): sum = ram_data_r + dw_in in W+1 bits, clamped to [WMIN, WMAX], registered into ram_data_w; ram_addr_w = issue address; ram_we=1 for exactly that cycle.
REQ-026 Read-to-write latency 2 cycles; peak throughput one weight per cycle; every address 0..M-1 written exactly once per pass, including dw_in=0.
REQ-027 sat_cnt increments when clamp active on a written weight; holds at 1023.
REQ-028 ext read of an address with write in flight returns pre-update RAM contents; no forwarding.
REQ-029 In IDLE/DONE ram_addr_r SHALL be ext_addr when ext_req=1, else 0; ram_we=0.
REQ-030 done SHALL assert only in DONE, coincident with busy still high; sat_cnt holds until next accepted start.
REQ-031 Index SHALL not exceed M-1; no wrap-around issue within a pass.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, ram_we=0, busy=0, done=0, ext_valid=0, sat_cnt=0, ram_addr_r=0, ram_addr_w=0, ram_data_w=0, index=0, in-flight tags cleared.
REQ-033 Reset mid-pass SHALL abandon remaining addresses; no write after rst asserts; next start restarts from address 0.

Verification
REQ-034 M=4, weights {10,20,30,40}, dw {1,-2,3,-4}, no ext_req -> writes {11,18,33,36} to addr 0..3 on consecutive cycles, first ram_we 2 cycles after start accepted, done 1 cycle after DRAIN empties, sat_cnt=0.
REQ-035 Weight WMAX-1 with dw=+5 and weight WMIN+1 with dw=-5 -> written WMAX and WMIN, sat_cnt=2.
REQ-036 ext_req held 3 cycles mid-pass -> update issue stalls 3 cycles, ext_valid high 3 cycles one cycle later, all M addresses still written once, done delayed by 3 cycles.
REQ-037 start pulsed during RUN and DONE -> ignored, no second pass, sat_cnt not cleared.
REQ-038 rst asserted after address 1 issued -> ram_we drops asynchronously, no write to address 1+, busy=0; subsequent start writes from address 0.
